// File: rtl/arb_multiplexer_if.sv
// Handshake/bus bundle for arb_multiplexer.
//   req_valid [N]       per-channel request valid      (producer -> arbiter)
//   req_data  [N*WIDTH] packed channel data, channel i at [i*WIDTH +: WIDTH]
//   req_ready [N]       per-channel accept, at most one bit high
//   out_valid           output register holds valid data
//   out_data  [WIDTH]   registered data of the granted channel
//   out_src   [SW]      index of the channel that produced out_data
//   out_ready           downstream accepts out_data this cycle
// Modports: slave = arbiter side, master = producer/consumer side.
interface arb_multiplexer_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned N     = 2,
  parameter int unsigned SW    = $clog2(N)
) ();

  logic [N-1:0]       req_valid;
  logic [N*WIDTH-1:0] req_data;
  logic [N-1:0]       req_ready;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic [SW-1:0]      out_src;
  logic               out_ready;

  modport slave (
    input  req_valid,
    input  req_data,
    input  out_ready,
    output req_ready,
    output out_valid,
    output out_data,
    output out_src
  );

  modport master (
    output req_valid,
    output req_data,
    output out_ready,
    input  req_ready,
    input  out_valid,
    input  out_data,
    input  out_src
  );

endinterface

// File: rtl/arb_multiplexer.sv
// N-channel valid/ready multiplexer with round-robin arbitration and a
// registered output stage (one cycle latency, full throughput).
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high reset
//   bus    arb_multiplexer_if.slave (request channels in, registered beat out)
// Configuration macro:
//   ARB_MULTIPLEXER_FIXED_PRIO_EN  when defined, lowest-index valid channel
//                                  always wins and no rotation pointer exists.
module arb_multiplexer #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned N     = 2,
  parameter int unsigned SW    = $clog2(N)
) (
  input logic               clk,
  input logic               reset,
  arb_multiplexer_if.slave  bus
);

  logic             load_en;
  logic             transfer;
  logic [N-1:0]     grant;
  logic             grant_any;
  logic [SW-1:0]    grant_idx;
  logic [WIDTH-1:0] sel_data;
  logic [SW-1:0]    rr_ptr;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SW-1:0]    out_src_q, out_src_d;

`ifdef ARB_MULTIPLEXER_FIXED_PRIO_EN
  // Fixed priority: search always starts at channel 0.
  assign rr_ptr = '0;
`else
  logic [SW-1:0] rr_ptr_q, rr_ptr_d;

  assign rr_ptr = rr_ptr_q;

  // Pointer moves past the winner only on an actual transfer; wraps at N, not 2^SW.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (transfer) begin
      if (grant_idx == SW'(N - 1)) begin
        rr_ptr_d = '0;
      end else begin
        rr_ptr_d = grant_idx + SW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end
`endif

  // Output register is empty or being drained this cycle.
  assign load_en  = !out_valid_q || bus.out_ready;
  assign transfer = grant_any && load_en;

  // Search upward from rr_ptr, wrapping N-1 -> 0; first valid channel wins.
  always_comb begin
    int unsigned   idx;
    logic [SW-1:0] idx_sw;
    idx       = 0;
    idx_sw    = '0;
    grant     = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = 32'(rr_ptr) + k;
      if (idx >= N) begin
        idx = idx - N;
      end
      idx_sw = SW'(idx);
      if (!grant_any && bus.req_valid[idx_sw]) begin
        grant_any = 1'b1;
        grant_idx = idx_sw;
      end
    end
    if (grant_any) begin
      grant[grant_idx] = 1'b1;
    end
  end

  // grant is one-hot, so an AND-OR mux suffices.
  always_comb begin
    sel_data = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (grant[i]) begin
        sel_data = sel_data | bus.req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign bus.req_ready = grant & {N{load_en}};

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    if (load_en) begin
      // With no grant the beat is drained but data/src keep their last value.
      out_valid_d = grant_any;
      if (grant_any) begin
        out_data_d = sel_data;
        out_src_d  = grant_idx;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_src   = out_src_q;

endmodule

// File: tb/tb_arb_multiplexer.sv
// Directed bench for arb_multiplexer: an N=4 instance for the main scenarios
// and an N=3 instance for the non-power-of-two wrap / fixed-priority case.
module tb_arb_multiplexer;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  arb_multiplexer_if #(.WIDTH(32), .N(4)) bus_a ();
  arb_multiplexer_if #(.WIDTH(32), .N(3)) bus_b ();

  arb_multiplexer #(.WIDTH(32), .N(4)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  arb_multiplexer #(.WIDTH(32), .N(3)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    bus_a.req_valid = '0;
    bus_a.req_data  = '0;
    bus_a.out_ready = 1'b1;
    bus_b.req_valid = '0;
    bus_b.req_data  = '0;
    bus_b.out_ready = 1'b1;

    // Reset / idle
    tick();
    tick();
    chk("rst_out_valid", 64'(bus_a.out_valid), 64'd0);
    chk("rst_out_data", 64'(bus_a.out_data), 64'd0);
    chk("rst_out_src", 64'(bus_a.out_src), 64'd0);
    chk("rst_req_ready", 64'(bus_a.req_ready), 64'd0);
    reset = 1'b0;
    tick();
    chk("idle_out_valid", 64'(bus_a.out_valid), 64'd0);
    chk("idle_out_data", 64'(bus_a.out_data), 64'd0);

    // Single channel 2
    bus_a.req_data  = {32'h0, 32'hDEADBEEF, 32'h0, 32'h0};
    bus_a.req_valid = 4'b0100;
    #1;
    chk("single_req_ready", 64'(bus_a.req_ready), 64'h4);
    tick();
    chk("single_out_valid", 64'(bus_a.out_valid), 64'd1);
    chk("single_out_data", 64'(bus_a.out_data), 64'hDEADBEEF);
    chk("single_out_src", 64'(bus_a.out_src), 64'd2);
    bus_a.req_valid = 4'b0000;
    tick();
    chk("drain_out_valid", 64'(bus_a.out_valid), 64'd0);
    chk("drain_data_hold", 64'(bus_a.out_data), 64'hDEADBEEF);

    // Pulse reset so the pointer starts at 0 for the rotation run
    #2 reset = 1'b1;
    #1 reset = 1'b0;

    // Round robin, all four valid
    bus_a.req_data  = {32'h13, 32'h12, 32'h11, 32'h10};
    bus_a.req_valid = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("rr_out_valid", 64'(bus_a.out_valid), 64'd1);
      chk("rr_out_src", 64'(bus_a.out_src), 64'(i % 4));
      chk("rr_out_data", 64'(bus_a.out_data), 64'(32'h10 + (i % 4)));
    end

    // Backpressure: beat 0x13 from ch3 held, pointer at 0
    bus_a.out_ready = 1'b0;
    bus_a.req_valid = 4'b1010;
    #1;
    chk("bp_req_ready0", 64'(bus_a.req_ready), 64'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_out_valid", 64'(bus_a.out_valid), 64'd1);
      chk("bp_out_src", 64'(bus_a.out_src), 64'd3);
      chk("bp_out_data", 64'(bus_a.out_data), 64'h13);
      chk("bp_req_ready", 64'(bus_a.req_ready), 64'd0);
    end
    bus_a.out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 64'(bus_a.req_ready), 64'h2);
    tick();
    chk("bp_next_src", 64'(bus_a.out_src), 64'd1);
    chk("bp_next_data", 64'(bus_a.out_data), 64'h11);
    chk("bp_next_ready", 64'(bus_a.req_ready), 64'h8);
    tick();
    chk("bp_next2_src", 64'(bus_a.out_src), 64'd3);

    // Reset mid-stream with pointer at 3
    bus_a.req_valid = 4'b0100;
    tick();
    chk("pre_rst_src", 64'(bus_a.out_src), 64'd2);
    chk("pre_rst_valid", 64'(bus_a.out_valid), 64'd1);
    bus_a.req_valid = 4'b1010;
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(bus_a.out_valid), 64'd0);
    chk("mid_rst_src", 64'(bus_a.out_src), 64'd0);
    chk("mid_rst_data", 64'(bus_a.out_data), 64'd0);
    #1 reset = 1'b0;
    #1;
    chk("post_rst_ready", 64'(bus_a.req_ready), 64'h2);
    tick();
    chk("post_rst_src", 64'(bus_a.out_src), 64'd1);
    chk("post_rst_data", 64'(bus_a.out_data), 64'h11);
    bus_a.req_valid = 4'b0000;

    // N=3 wrap (or fixed priority when the macro is defined)
    bus_b.req_data  = {32'h22, 32'h21, 32'h20};
    bus_b.req_valid = 3'b111;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("n3_out_valid", 64'(bus_b.out_valid), 64'd1);
`ifdef ARB_MULTIPLEXER_FIXED_PRIO_EN
      chk("n3_out_src", 64'(bus_b.out_src), 64'd0);
      chk("n3_out_data", 64'(bus_b.out_data), 64'h20);
`else
      chk("n3_out_src", 64'(bus_b.out_src), 64'(i % 3));
      chk("n3_out_data", 64'(bus_b.out_data), 64'(32'h20 + (i % 3)));
`endif
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/arb_multiplexer.md
Name: arb_multiplexer

Overview:
- Parametrised successor of the 2:1 datapath mux: N-channel multiplexer with valid/ready handshakes, round-robin arbitration and a registered output stage.
- Shares one downstream port among several producers, e.g. instruction-fetch and load/store paths on a unified memory port, or extra writeback sources in the pipelined core.
- Output is registered: one cycle of latency, full throughput, no combinational path from out_ready to any req_ready other than through the load enable.

Parameters:
- WIDTH, 32, data width of each channel and of the output.
- N, 2, number of input channels; legal range 2..16.
- SW, $clog2(N), width of the source-index field (derived; do not override).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  N  per-channel request valid.
- req_data  input  N*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- req_ready  output  N  per-channel accept; at most one bit high per cycle.
- out_valid  output  1  output register holds valid data.
- out_data  output  WIDTH  registered data of the granted channel.
- out_src  output  SW  index of the channel that produced out_data.
- out_ready  input  1  downstream accepts out_data this cycle.

Behaviour:
- Reset (asynchronous, immediate): out_valid=0, out_data=0, out_src=0, rr_ptr=0. req_ready is combinational and is therefore 0 while out_valid=0 only if no req_valid is high; see load rule.
- load_en = !out_valid || out_ready. This means the output register is empty or is being drained this cycle.
- Arbitration (combinational): grant the first channel with req_valid=1, searching upward from rr_ptr and wrapping from N-1 to 0. If no channel has req_valid=1, there is no grant.
- req_ready[i] = grant[i] && load_en. A transfer on channel i occurs when req_valid[i] && req_ready[i].
- On a transfer:
  - out_data <= req_data[i], out_src <= i, out_valid <= 1.
  - rr_ptr <= i+1, wrapping to 0 when i = N-1.
- If load_en=1 and there is no grant: out_valid <= 0; out_data and out_src hold their values.
- If load_en=0: out_valid, out_data, out_src and rr_ptr all hold. out_data and out_src must not change while out_valid=1 && out_ready=0.
- Latency: data accepted in cycle t appears on out_data in cycle t+1.
- Throughput: one transfer per cycle when out_ready is held high. A simultaneous drain and load in the same cycle is legal and produces back-to-back beats.
- Fairness: with all N channels continuously valid and out_ready=1, grants rotate 0,1,...,N-1,0,... No channel waits more than N-1 transfers.
- rr_ptr advances only on a transfer, never on stall or idle cycles.
- Reset asserted mid-operation: the beat held in the output register is dropped and the pointer returns to 0. The next grant after reset goes to the lowest valid channel.
- Non-power-of-two N: rr_ptr wraps at N, not at 2^SW. Values of out_src >= N never occur.
- A producer may deassert req_valid without a handshake; the arbiter re-evaluates every cycle and has no lock.

Optional Feature:
- Macro: ARB_MULTIPLEXER_FIXED_PRIO_EN.
- Defined: fixed priority. The lowest-index valid channel always wins; rr_ptr is not implemented and is treated as constant 0. All other handshake and register behaviour is unchanged. Starvation of higher-index channels is permitted.
- Undefined (default): round-robin as specified above.

Test Plan:
- Reset/idle: assert reset for 2 cycles with req_valid=0 -> out_valid=0, out_data=0, out_src=0, req_ready=0. Release with no requests -> outputs unchanged.
- Single channel, N=4, WIDTH=32: req_valid=4'b0100 with data 0xDEADBEEF, out_ready=1 -> req_ready=4'b0100 in cycle t. In cycle t+1: out_valid=1, out_data=0xDEADBEEF, out_src=2.
- Round-robin, N=4: all channels valid with data 0x10..0x13, out_ready=1 for 8 cycles -> out_src sequence 0,1,2,3,0,1,2,3 and one beat per cycle.
- Backpressure: a beat is held with out_ready=0 for 5 cycles while channels 1 and 3 remain valid -> req_ready=0, out_data/out_src stable, rr_ptr unchanged. After out_ready returns to 1, the same-cycle drain and load occurs and the next beat appears the following cycle.
- Reset mid-stream: assert reset asynchronously mid-cycle while out_valid=1 and rr_ptr=3 -> out_valid drops immediately. After release with req_valid=4'b1010, the first grant goes to channel 1.
- N=3 wrap plus fixed-priority build:
  - N=3, all channels valid -> out_src sequence 0,1,2,0 and never 3.
  - With ARB_MULTIPLEXER_FIXED_PRIO_EN defined and the same stimulus -> out_src is 0 every cycle.
